// File: rtl/oam_dma_controller.sv
// Sprite DMA engine: snoops CPU writes to the DMA page register, stalls the
// CPU through rdy, and copies one 256-byte page to the OAM data port.
// When idle the CPU bus is passed straight through to memory.
module oam_dma_controller #(
  parameter int                    ADDR_WIDTH    = 16,
  parameter int                    REG_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [REG_WIDTH-1:0]  cpu_dout,
  input  logic                  cpu_we,
  input  logic [REG_WIDTH-1:0]  mem_din,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_dout,
  output logic                  mem_we,
  output logic                  rdy,
  output logic                  dma_active,
  output logic [7:0]            xfer_index
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t               state, state_d;
  logic                 parity;
  logic [REG_WIDTH-1:0] page;
  logic [7:0]           index;
  logic [REG_WIDTH-1:0] data_latch;

  logic                 trigger;
  logic                 load_page;
  logic                 inc_index;
  logic                 latch_data;

  assign trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);

  // State, alignment parity and transfer bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      parity     <= 1'b0;
      page       <= '0;
      index      <= '0;
      data_latch <= '0;
    end else begin
      state  <= state_d;
      parity <= ~parity;
      if (load_page) begin
        page  <= cpu_dout;
        index <= '0;
      end else if (inc_index) begin
        index <= index + 8'd1;
      end
      if (latch_data) begin
        data_latch <= mem_din;
      end
    end
  end

  // Next-state decode and memory bus steering
  always_comb begin
    state_d    = state;
    load_page  = 1'b0;
    inc_index  = 1'b0;
    latch_data = 1'b0;
    mem_addr   = cpu_addr;
    mem_dout   = cpu_dout;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        // The triggering write still reaches memory.
        mem_we = cpu_we;
        if (trigger) begin
          load_page = 1'b1;
          state_d   = HALT;
        end
      end
      HALT: begin
        // Reads must land on even-parity cycles; insert ALIGN otherwise.
        state_d = parity ? READ : ALIGN;
      end
      ALIGN: begin
        state_d = READ;
      end
      READ: begin
        // Page and index are concatenated, so there is no carry out of the page.
        mem_addr   = {page, index};
        latch_data = 1'b1;
        state_d    = WRITE;
      end
      WRITE: begin
        mem_addr = OAM_DATA_ADDR;
        mem_dout = data_latch;
        mem_we   = 1'b1;
        if (index == 8'hFF) begin
          state_d = IDLE;
        end else begin
          inc_index = 1'b1;
          state_d   = READ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // CPU handshake derived from registered state only
  assign rdy        = (state == IDLE);
  assign dma_active = (state != IDLE);
  assign xfer_index = index;

endmodule
